mem_access_ctrl: RTL and testbench

- Sequences every data-memory load/store from the execute/memory stage onto a single-outstanding memory port.
- Computes the word-aligned address, byte enables and lane-replicated store data.
- Extracts and extends load data, and flags misaligned or illegal-size requests without touching memory.
- Sits between the pipeline memory stage and the data cache/arbiter port.

---
 rtl/rv32i_types.sv | 21 ++
 rtl/store_align.sv | 39 +++
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the data-memory access path.
//   rv32i_word       : 32-bit machine word
//   mem_size_t       : access size encoding used on req_type (2'b11 is illegal)
//   mem_ctrl_state_t : mem_access_ctrl sequencer states
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_ctrl_state_t;

endpackage

// File: rtl/store_align.sv
// Store lane alignment (purely combinational).
// Ports:
//   req_type    in  2   access size (word/byte/half; 2'b11 yields no lanes)
//   addr        in  2   byte offset within the word
//   wdata       in  32  right-aligned store data
//   byte_enable out 4   lanes written by this store
//   wdata_rep   out 32  store data replicated across all candidate lanes
module store_align
  import rv32i_types::*;
(
  input  logic [1:0] req_type,
  input  logic [1:0] addr,
  input  rv32i_word  wdata,
  output logic [3:0] byte_enable,
  output rv32i_word  wdata_rep
);

  always_comb begin
    byte_enable = 4'b0000;
    wdata_rep   = wdata;
    case (req_type)
      MEM_BYTE: begin
        byte_enable = 4'b0001 << addr;
        wdata_rep   = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        byte_enable = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep   = {2{wdata[15:0]}};
      end
      MEM_WORD: begin
        byte_enable = 4'b1111;
      end
      default: begin
        byte_enable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: takes one load/store at a time from the
// memory stage, drives a single-outstanding memory port, and returns the
// extended load data (or an error) to the pipeline.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write, req_type,
//   req_unsigned, req_addr,
//   req_wdata                  request fields
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_error       response payload
//   mem_read, mem_write,
//   mem_address,
//   mem_byte_enable, mem_wdata memory command (held until mem_resp)
//   mem_rdata, mem_resp        memory completion
// Optional build macro MEM_TIMEOUT_EN: abort an access that waits
// TIMEOUT_CYCLES cycles without mem_resp and report it as an error.
module mem_access_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_type,
  input  logic        req_unsigned,
  input  rv32i_word   req_addr,
  input  rv32i_word   req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output rv32i_word   rsp_rdata,
  output logic        rsp_error,
  output logic        mem_read,
  output logic        mem_write,
  output rv32i_word   mem_address,
  output logic [3:0]  mem_byte_enable,
  output rv32i_word   mem_wdata,
  input  rv32i_word   mem_rdata,
  input  logic        mem_resp
);

  mem_ctrl_state_t state_q, state_d;

  logic        write_p1, unsigned_p1;
  logic [1:0]  type_p1;
  rv32i_word   addr_p1, wdata_p1;
  logic [3:0]  be_p1;
  rv32i_word   rdata_p2;
  logic        error_p2;

  logic        accept, misaligned, complete, timeout_hit;
  logic [3:0]  be_al;
  rv32i_word   wdata_al;

  function automatic rv32i_word load_extract(rv32i_word raw, logic [1:0] typ,
                                             logic [1:0] off, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[8*off +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (typ)
      MEM_BYTE: load_extract = {{24{b[7] & ~uns}}, b};
      MEM_HALF: load_extract = {{16{h[15] & ~uns}}, h};
      default:  load_extract = raw;
    endcase
  endfunction

  store_align u_store_align (
    .req_type    (req_type),
    .addr        (req_addr[1:0]),
    .wdata       (req_wdata),
    .byte_enable (be_al),
    .wdata_rep   (wdata_al)
  );

  assign accept     = (state_q == IDLE) && req_valid;
  assign complete   = (state_q == ACCESS) && mem_resp;
  assign misaligned = (req_type == 2'b11) ||
                      ((req_type == MEM_HALF) && req_addr[0]) ||
                      ((req_type == MEM_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts ACCESS cycles without mem_resp; zero whenever not in ACCESS so
  // every new access starts from a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      wait_cnt_q <= '0;
    end else if (!mem_resp) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Fires on the cycle whose increment would bring the count to
  // TIMEOUT_CYCLES; a concurrent mem_resp takes priority.
  assign timeout_hit = (state_q == ACCESS) && !mem_resp &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    rsp_error       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_enable = 4'b0000;
    mem_wdata       = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_read        = ~write_p1;
        mem_write       = write_p1;
        mem_address     = {addr_p1[31:2], 2'b00};
        mem_byte_enable = be_p1;
        mem_wdata       = write_p1 ? wdata_p1 : '0;
        if (complete || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_p2;
        rsp_error = error_p2;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: request captured at accept, drives the memory port.
  // Stage p2: response payload captured at completion/abort; a rejected
  // request loads its error response directly at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p1    <= req_write;
      unsigned_p1 <= req_unsigned;
      type_p1     <= req_type;
      addr_p1     <= req_addr;
      be_p1       <= req_write ? be_al : 4'b0000;
      wdata_p1    <= wdata_al;
      rdata_p2    <= '0;
      error_p2    <= misaligned;
    end else if (complete) begin
      rdata_p2 <= write_p1 ? '0 :
                  load_extract(mem_rdata, type_p1, addr_p1[1:0], unsigned_p1);
      error_p2 <= 1'b0;
    end else if (timeout_hit) begin
      rdata_p2 <= '0;
      error_p2 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;
  bit  done = 1'b0;

  // Expected DUT outputs for the current cycle, set by the driver.
  logic        e_req_ready = 1'b1, e_rsp_valid = 1'b0, e_rsp_error = 1'b0;
  logic [31:0] e_rsp_rdata = '0;
  logic        e_mem_read = 1'b0, e_mem_write = 1'b0;
  logic [31:0] e_mem_address = '0, e_mem_wdata = '0;
  logic [3:0]  e_be = '0;

  // ---------------- reference model ----------------
  function automatic bit m_illegal(logic [1:0] t, logic [31:0] a);
    return (t == 2'd3) || (t == 2'd2 && a[0]) || (t == 2'd0 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] m_be(logic w, logic [1:0] t, logic [31:0] a);
    if (!w) return 4'd0;
    if (t == 2'd1) return 4'(1 << a[1:0]);
    if (t == 2'd2) return a[1] ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] t, logic [31:0] d);
    if (t == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
    if (t == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] raw, logic [1:0] t,
                                         logic [31:0] a, logic u);
    logic [31:0] v;
    if (t == 2'd1) begin
      v = (raw >> (8 * a[1:0])) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (t == 2'd2) begin
      v = (raw >> (16 * a[1])) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return raw;
  endfunction

  task automatic exp_idle();
    e_req_ready = 1'b1; e_rsp_valid = 1'b0; e_rsp_error = 1'b0; e_rsp_rdata = '0;
    e_mem_read = 1'b0; e_mem_write = 1'b0; e_mem_address = '0; e_be = '0;
    e_mem_wdata = '0;
  endtask

  task automatic exp_access(logic w, logic [1:0] t, logic [31:0] a, logic [31:0] d);
    exp_idle();
    e_req_ready   = 1'b0;
    e_mem_read    = !w;
    e_mem_write   = w;
    e_mem_address = a & 32'hFFFF_FFFC;
    e_be          = m_be(w, t, a);
    e_mem_wdata   = w ? m_wdata(t, d) : 32'd0;
  endtask

  task automatic exp_resp(logic err, logic [31:0] data);
    exp_idle();
    e_req_ready = 1'b0;
    e_rsp_valid = 1'b1;
    e_rsp_error = err;
    e_rsp_rdata = data;
  endtask

  // ---------------- single compare process ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    // Hand-computed values pin the model itself.
    chk("pin_lb",   m_load(32'h80FF_1234, 2'd1, 32'h1002, 1'b0), 32'hFFFF_FFFF);
    chk("pin_lbu",  m_load(32'h80FF_1234, 2'd1, 32'h1002, 1'b1), 32'h0000_00FF);
    chk("pin_lh2",  m_load(32'h8001_7FFF, 2'd2, 32'h2002, 1'b0), 32'hFFFF_8001);
    chk("pin_lh0",  m_load(32'h8001_7FFF, 2'd2, 32'h2000, 1'b0), 32'h0000_7FFF);
    chk("pin_be",   {28'd0, m_be(1'b1, 2'd2, 32'h3002)}, 32'h0000_000C);
    chk("pin_wd",   m_wdata(2'd2, 32'h0000_BEEF), 32'hBEEF_BEEF);
    chk("pin_be_b", {28'd0, m_be(1'b1, 2'd1, 32'h0000_0003)}, 32'h0000_0008);
    forever begin
      @(negedge clk);
      if (done) break;
      if (chk_en) begin
        chk("req_ready",   {31'd0, req_ready},  {31'd0, e_req_ready});
        chk("rsp_valid",   {31'd0, rsp_valid},  {31'd0, e_rsp_valid});
        chk("rsp_error",   {31'd0, rsp_error},  {31'd0, e_rsp_error});
        chk("rsp_rdata",   rsp_rdata,           e_rsp_rdata);
        chk("mem_read",    {31'd0, mem_read},   {31'd0, e_mem_read});
        chk("mem_write",   {31'd0, mem_write},  {31'd0, e_mem_write});
        chk("mem_address", mem_address,         e_mem_address);
        chk("mem_be",      {28'd0, mem_byte_enable}, {28'd0, e_be});
        chk("mem_wdata",   mem_wdata,           e_mem_wdata);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k: cycle of ACCESS on which mem_resp arrives; h: cycles rsp_ready held low.
  task automatic do_txn(logic w, logic [1:0] t, logic u, logic [31:0] a,
                        logic [31:0] d, logic [31:0] raw, int k, int h);
    int lim;
    req_valid = 1'b1; req_write = w; req_type = t; req_unsigned = u;
    req_addr = a; req_wdata = d;
    mem_resp = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    mem_resp  = 1'b0;
    if (m_illegal(t, a)) begin
      exp_resp(1'b1, 32'd0);
    end else begin
      lim = k;
`ifdef MEM_TIMEOUT_EN
      if (k > int'(TO)) lim = int'(TO);
`endif
      exp_access(w, t, a, d);
      for (int c = 1; c <= lim; c++) begin
        mem_resp  = (c == k);
        mem_rdata = (c == k) ? raw : $urandom;
        step();
      end
      mem_resp = 1'b0;
      if (k > lim) exp_resp(1'b1, 32'd0);
      else         exp_resp(1'b0, w ? 32'd0 : m_load(raw, t, a, u));
    end
    for (int i = 0; i < h; i++) begin
      rsp_ready = 1'b0;
      mem_resp  = 1'($urandom_range(0, 1));
      step();
    end
    rsp_ready = 1'b1;
    mem_resp  = 1'($urandom_range(0, 1));
    step();
    rsp_ready = 1'b0;
    mem_resp  = 1'b0;
    exp_idle();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    exp_idle();
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    do_txn(1'b0, 2'd1, 1'b0, 32'h1002, 32'd0, 32'h80FF_1234, 1, 0);
    do_txn(1'b0, 2'd1, 1'b1, 32'h1002, 32'd0, 32'h80FF_1234, 2, 1);
    do_txn(1'b0, 2'd2, 1'b0, 32'h2002, 32'd0, 32'h8001_7FFF, 1, 0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 32'h8001_7FFF, 3, 0);
    do_txn(1'b1, 2'd2, 1'b0, 32'h3002, 32'h0000_BEEF, 32'h1234_5678, 2, 0);
    do_txn(1'b0, 2'd0, 1'b0, 32'h4001, 32'd0, 32'd0, 1, 3);
    do_txn(1'b0, 2'd3, 1'b0, 32'h4000, 32'd0, 32'd0, 1, 3);

    // Reset while a load is outstanding: strobes drop, later mem_resp is ignored.
    req_valid = 1'b1; req_write = 1'b0; req_type = 2'd0; req_addr = 32'h5000;
    step();
    req_valid = 1'b0;
    exp_access(1'b0, 2'd0, 32'h5000, 32'd0);
    step();
    rst_n = 1'b0;
    exp_idle();
    step();
    rst_n = 1'b1;
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp = 1'b0;
    step(); step();

`ifdef MEM_TIMEOUT_EN
    do_txn(1'b0, 2'd0, 1'b0, 32'h6000, 32'd0, 32'hCAFE_0001, 5, 1);
    do_txn(1'b0, 2'd0, 1'b0, 32'h6004, 32'd0, 32'hCAFE_0002, 4, 0);
    do_txn(1'b1, 2'd1, 1'b0, 32'h6005, 32'h77, 32'd0, 9, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [1:0] t;
      logic [31:0] a;
      t = 2'($urandom_range(0, 3));
      a = $urandom;
      // Bias towards legal alignment so most transactions reach memory.
      if ($urandom_range(0, 3) != 0) begin
        if (t == 2'd0) a[1:0] = 2'd0;
        if (t == 2'd2) a[0] = 1'b0;
      end
      do_txn(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), a,
             $urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_resp  = 1'($urandom_range(0, 1));
        rsp_ready = 1'($urandom_range(0, 1));
        step();
      end
      mem_resp = 1'b0;
      rsp_ready = 1'b0;
    end

    step();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
